// File: rtl/gpio_pkg.sv
// gpio_pkg
//   Shared definitions for the GPIO pad-side logic: pin mode encodings of the
//   2-bit per-pin field in the GPIO control register, the maximum pin count
//   and a helper that extracts one pin's mode field.
//   Build option: GPIO_DEBOUNCE_EN (used by gpio_in_filter) enables the
//   input debounce counters.
package gpio_pkg;

    typedef logic [1:0] gpio_mode_t;

    localparam int GPIO_MAX_NUM = 16;

    localparam gpio_mode_t GPIO_MODE_HIZ = 2'b00;
    localparam gpio_mode_t GPIO_MODE_OUT = 2'b01;
    localparam gpio_mode_t GPIO_MODE_IN  = 2'b10;
    localparam gpio_mode_t GPIO_MODE_RSV = 2'b11;

    // Mode field of pin idx inside the control register image.
    function automatic gpio_mode_t pin_mode(input logic [31:0] ctrl, input int idx);
        return ctrl[2*idx +: 2];
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// gpio_in_filter
//   Single-pin input conditioning: synchroniser, optional debounce and
//   edge outputs derived from the accepted (stable) level.
//   Build option: GPIO_DEBOUNCE_EN
//     defined   : 2-flop synchroniser followed by a debounce counter; a new
//                 level is accepted after DEBOUNCE_CYCLES consecutive
//                 synchronised samples; pad-to-stable latency 2+DEBOUNCE_CYCLES.
//     undefined : no counter; the stable flop is the second synchroniser
//                 stage, so pad-to-stable latency is 2 edges.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     pad_i     : raw asynchronous pad input
//     stable_o  : accepted level (registered)
//     rise_o    : stable level goes 0->1 at the coming clock edge
//     fall_o    : stable level goes 1->0 at the coming clock edge
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync1_d;
    logic stable_q, stable_d;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = pad_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            // Back at (or still at) the accepted level: any partial run restarts.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    // Without debounce the stable flop doubles as the second synchroniser
    // stage, giving a 2-edge pad-to-output latency.
    logic unused_cfg;
    assign unused_cfg = (DEBOUNCE_CYCLES < 1);

    always_comb begin
        sync1_d  = pad_i;
        stable_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            stable_q <= stable_d;
        end
    end
`endif

    // Edges are reported combinationally from the next stable value so the
    // pending flop in the top level updates on the same edge as stable_q.
    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;
    assign fall_o   = ~stable_d & stable_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
//   Pad-side counterpart of the GPIO register block. Decodes the per-pin mode
//   from reg_ctrl into registered pad output / output-enable lines, returns
//   conditioned pad levels on io_in_o, and keeps per-pin edge-interrupt
//   pending bits (write-1-to-clear) with an OR-ed interrupt request.
//   Build option: GPIO_DEBOUNCE_EN selects debounced inputs (see gpio_in_filter).
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     reg_ctrl        : control image, pin i mode in [2i+1:2i]
//                       (00 hi-Z, 01 output, 10 input, 11 treated as hi-Z)
//     reg_data        : data image, bit i drives pin i in output mode
//     io_pad_i        : raw pad inputs
//     io_pad_o/io_oe_o: registered pad value / output enable
//     io_in_o         : conditioned input levels (all pins, any mode)
//     irq_rise_en_i   : per-pin rising-edge interrupt enable
//     irq_fall_en_i   : per-pin falling-edge interrupt enable
//     irq_clr_i       : per-pin clear pulses for pending bits
//     irq_pend_o      : pending bits
//     int_o           : OR of pending bits
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_NUM        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         reg_ctrl,
    input  logic [31:0]         reg_data,
    input  logic [GPIO_NUM-1:0] io_pad_i,
    output logic [GPIO_NUM-1:0] io_pad_o,
    output logic [GPIO_NUM-1:0] io_oe_o,
    output logic [GPIO_NUM-1:0] io_in_o,
    input  logic [GPIO_NUM-1:0] irq_rise_en_i,
    input  logic [GPIO_NUM-1:0] irq_fall_en_i,
    input  logic [GPIO_NUM-1:0] irq_clr_i,
    output logic [GPIO_NUM-1:0] irq_pend_o,
    output logic                int_o
);

    logic [GPIO_NUM-1:0] pad_q, pad_d;
    logic [GPIO_NUM-1:0] oe_q, oe_d;
    logic [GPIO_NUM-1:0] pend_q, pend_d;
    logic [GPIO_NUM-1:0] in_stable, in_rise, in_fall;

    // Control/data bits of pins at or above GPIO_NUM are ignored.
    logic unused_regs;
    assign unused_regs = ^{reg_ctrl, reg_data};

    for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
        gpio_in_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_in_filter (
            .clk      (clk),
            .rst      (rst),
            .pad_i    (io_pad_i[g]),
            .stable_o (in_stable[g]),
            .rise_o   (in_rise[g]),
            .fall_o   (in_fall[g])
        );
    end

    always_comb begin
        oe_d   = '0;
        pad_d  = '0;
        pend_d = pend_q;
        for (int i = 0; i < GPIO_NUM; i++) begin
            // Only mode 01 drives; hi-Z, input and reserved all release the pad.
            oe_d[i]  = (pin_mode(reg_ctrl, i) == GPIO_MODE_OUT);
            pad_d[i] = (pin_mode(reg_ctrl, i) == GPIO_MODE_OUT) & reg_data[i];
            // A qualifying edge wins over a coincident clear.
            if ((pin_mode(reg_ctrl, i) == GPIO_MODE_IN) &&
                ((in_rise[i] && irq_rise_en_i[i]) || (in_fall[i] && irq_fall_en_i[i]))) begin
                pend_d[i] = 1'b1;
            end else if (irq_clr_i[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q  <= '0;
            oe_q   <= '0;
            pend_q <= '0;
        end else begin
            pad_q  <= pad_d;
            oe_q   <= oe_d;
            pend_q <= pend_d;
        end
    end

    assign io_pad_o   = pad_q;
    assign io_oe_o    = oe_q;
    assign io_in_o    = in_stable;
    assign irq_pend_o = pend_q;
    assign int_o      = |pend_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl
//   Bench for gpio_pad_ctrl: output-decode vector table, hand sequences for
//   latency, interrupt set/clear and mode gating, then random traffic against
//   a reference model that derives the accepted input level from a history of
//   pad samples (a new level is accepted once the last WIN samples, seen OFF
//   edges back, all differ from the current level).
module tb_gpio_pad_ctrl;

    localparam int N  = 16;
    localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int OFF = 2;
    localparam int WIN = DB;
`else
    localparam int OFF = 1;
    localparam int WIN = 1;
`endif
    localparam int LAT = OFF + WIN;

    logic          clk;
    logic          rst;
    logic [31:0]   reg_ctrl;
    logic [31:0]   reg_data;
    logic [N-1:0]  io_pad_i;
    logic [N-1:0]  io_pad_o;
    logic [N-1:0]  io_oe_o;
    logic [N-1:0]  io_in_o;
    logic [N-1:0]  irq_rise_en_i;
    logic [N-1:0]  irq_fall_en_i;
    logic [N-1:0]  irq_clr_i;
    logic [N-1:0]  irq_pend_o;
    logic          int_o;

    gpio_pad_ctrl #(
        .GPIO_NUM        (N),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_ctrl      (reg_ctrl),
        .reg_data      (reg_data),
        .io_pad_i      (io_pad_i),
        .io_pad_o      (io_pad_o),
        .io_oe_o       (io_oe_o),
        .io_in_o       (io_in_o),
        .irq_rise_en_i (irq_rise_en_i),
        .irq_fall_en_i (irq_fall_en_i),
        .irq_clr_i     (irq_clr_i),
        .irq_pend_o    (irq_pend_o),
        .int_o         (int_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [N-1:0] m_stable;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_oe;
    logic [N-1:0] m_pad;
    logic [N-1:0] s_hist[$];

    int checks;
    int passes;

    typedef struct {
        logic [31:0]  ctrl;
        logic [31:0]  data;
        logic [N-1:0] oe;
        logic [N-1:0] pad;
    } out_vec_t;

    out_vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock edge: capture the inputs, advance the model, compare outputs.
    task automatic tick();
        logic         r;
        logic [31:0]  c;
        logic [31:0]  d;
        logic [N-1:0] p;
        logic [N-1:0] re;
        logic [N-1:0] fe;
        logic [N-1:0] cl;
        logic [N-1:0] new_st;
        logic [1:0]   mode;
        logic         all_diff;
        logic         set;
        r  = rst;
        c  = reg_ctrl;
        d  = reg_data;
        p  = io_pad_i;
        re = irq_rise_en_i;
        fe = irq_fall_en_i;
        cl = irq_clr_i;
        @(posedge clk);
        #1;
        if (r) begin
            s_hist.push_back('0);
            m_stable = '0;
            m_pend   = '0;
            m_oe     = '0;
            m_pad    = '0;
        end else begin
            s_hist.push_back(p);
            new_st = m_stable;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < WIN; k++) begin
                    if (s_hist[s_hist.size() - 1 - OFF - k][i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) new_st[i] = ~m_stable[i];
                mode = c[2*i +: 2];
                set = (mode == 2'b10) &&
                      ((new_st[i] && !m_stable[i] && re[i]) || (!new_st[i] && m_stable[i] && fe[i]));
                if (set) m_pend[i] = 1'b1;
                else if (cl[i]) m_pend[i] = 1'b0;
                m_oe[i]  = (mode == 2'b01);
                m_pad[i] = (mode == 2'b01) && d[i];
            end
            m_stable = new_st;
        end
        if (s_hist.size() > 40) void'(s_hist.pop_front());
        check("io_oe_o",    32'(io_oe_o),    32'(m_oe));
        check("io_pad_o",   32'(io_pad_o),   32'(m_pad));
        check("io_in_o",    32'(io_in_o),    32'(m_stable));
        check("irq_pend_o", 32'(irq_pend_o), 32'(m_pend));
        check("int_o",      32'(int_o),      32'(|m_pend));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic        found;
        logic [31:0] m;

        checks = 0;
        passes = 0;
        m_stable = '0;
        m_pend   = '0;
        m_oe     = '0;
        m_pad    = '0;
        for (int i = 0; i < 8; i++) s_hist.push_back('0);

        vecs[0] = '{32'h0000_0001, 32'h0000_0001, 16'h0001, 16'h0001};
        vecs[1] = '{32'h0000_0003, 32'h0000_0001, 16'h0000, 16'h0000};
        vecs[2] = '{32'h5555_5555, 32'h0000_A5A5, 16'hFFFF, 16'hA5A5};
        vecs[3] = '{32'hAAAA_AAAA, 32'h0000_FFFF, 16'h0000, 16'h0000};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 16'h0000, 16'h0000};
        vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 16'h0000, 16'h0000};
        vecs[6] = '{32'h9999_9999, 32'hFFFF_FFFF, 16'h5555, 16'h5555};
        vecs[7] = '{32'h6666_6666, 32'h0000_0F0F, 16'hAAAA, 16'h0A0A};
        vecs[8] = '{32'h5555_5555, 32'hFFFF_0000, 16'hFFFF, 16'h0000};
        vecs[9] = '{32'h0000_000D, 32'h0000_0003, 16'h0001, 16'h0001};

        rst           = 1'b1;
        reg_ctrl      = '0;
        reg_data      = '0;
        io_pad_i      = '0;
        irq_rise_en_i = '0;
        irq_fall_en_i = '0;
        irq_clr_i     = '0;

        // Reset: everything held at zero while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            reg_ctrl      = 32'h5555_5555;
            reg_data      = $urandom;
            io_pad_i      = N'($urandom);
            irq_rise_en_i = '1;
            irq_fall_en_i = '1;
            tick();
            check("rst_oe",   32'(io_oe_o),    32'h0);
            check("rst_pad",  32'(io_pad_o),   32'h0);
            check("rst_in",   32'(io_in_o),    32'h0);
            check("rst_pend", 32'(irq_pend_o), 32'h0);
            check("rst_int",  32'(int_o),      32'h0);
        end
        rst           = 1'b0;
        reg_ctrl      = '0;
        reg_data      = '0;
        io_pad_i      = '0;
        irq_rise_en_i = '0;
        irq_fall_en_i = '0;
        ticks(LAT + 2);

        // Output decode table
        for (int i = 0; i < 10; i++) begin
            reg_ctrl = vecs[i].ctrl;
            reg_data = vecs[i].data;
            tick();
            check("vec_oe",  32'(io_oe_o),  32'(vecs[i].oe));
            check("vec_pad", 32'(io_pad_o), 32'(vecs[i].pad));
        end

        // Input latency and rise interrupt on pin 1
        reg_ctrl      = 32'h0000_0008;
        reg_data      = '0;
        irq_rise_en_i = 16'h0002;
        irq_fall_en_i = '0;
        ticks(2);
        io_pad_i[1] = 1'b1;
        cnt   = 0;
        found = 1'b0;
        for (int t = 1; t <= LAT + 4 && !found; t++) begin
            tick();
            if (io_in_o[1]) begin
                found = 1'b1;
                cnt   = t;
            end
        end
        check("lat_edges", 32'(cnt), 32'(LAT));
        check("lat_pend",  32'(irq_pend_o[1]), 32'h1);
        check("lat_int",   32'(int_o), 32'h1);

        // Clear pulse
        irq_clr_i = 16'h0002;
        tick();
        irq_clr_i = '0;
        check("clr_int", 32'(int_o), 32'h0);

        // Clear coinciding with a new rise: set wins
        io_pad_i[1] = 1'b0;
        ticks(LAT + 1);
        io_pad_i[1] = 1'b1;
        ticks(LAT - 1);
        irq_clr_i = 16'h0002;
        tick();
        irq_clr_i = '0;
        check("coinc_in",   32'(io_in_o[1]),    32'h1);
        check("coinc_pend", 32'(irq_pend_o[1]), 32'h1);
        irq_clr_i = 16'h0002;
        tick();
        irq_clr_i = '0;

`ifdef GPIO_DEBOUNCE_EN
        // Short high pulse is rejected
        io_pad_i[1] = 1'b0;
        ticks(LAT + 1);
        irq_clr_i = 16'h0002;
        tick();
        irq_clr_i = '0;
        io_pad_i[1] = 1'b1;
        ticks(DB - 1);
        io_pad_i[1] = 1'b0;
        for (int t = 0; t < LAT + 3; t++) begin
            tick();
            check("glitch_in", 32'(io_in_o[1]), 32'h0);
        end
`else
        // One-cycle pulse on pin 0 passes through, two edges later
        reg_ctrl      = 32'h0000_000A;
        irq_rise_en_i = 16'h0001;
        io_pad_i[1]   = 1'b0;
        ticks(3);
        io_pad_i[0] = 1'b1;
        tick();
        io_pad_i[0] = 1'b0;
        check("pulse_e1", 32'(io_in_o[0]), 32'h0);
        tick();
        check("pulse_e2",   32'(io_in_o[0]),    32'h1);
        check("pulse_pend", 32'(irq_pend_o[0]), 32'h1);
        tick();
        check("pulse_e3", 32'(io_in_o[0]), 32'h0);
        irq_clr_i = 16'h0001;
        tick();
        irq_clr_i = '0;
`endif

        // Mode gating on pin 2
        reg_ctrl      = 32'h0000_0000;
        irq_rise_en_i = 16'h0004;
        irq_fall_en_i = 16'h0004;
        io_pad_i      = '0;
        ticks(LAT + 1);
        io_pad_i[2] = 1'b1;
        ticks(LAT);
        check("gate_in_hi", 32'(io_in_o[2]),    32'h1);
        check("gate_pend1", 32'(irq_pend_o[2]), 32'h0);
        io_pad_i[2] = 1'b0;
        ticks(LAT);
        check("gate_in_lo", 32'(io_in_o[2]),    32'h0);
        check("gate_pend2", 32'(irq_pend_o[2]), 32'h0);
        reg_ctrl    = 32'h0000_0020;
        io_pad_i[2] = 1'b1;
        ticks(LAT);
        check("gate_pend3", 32'(irq_pend_o[2]), 32'h1);
        check("gate_int",   32'(int_o),         32'h1);
        irq_clr_i = 16'h0004;
        tick();
        irq_clr_i = '0;

        // Random traffic against the model
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 15) == 0) reg_ctrl = $urandom;
            if ($urandom_range(0, 3) == 0) reg_data = $urandom;
            if ($urandom_range(0, 31) == 0) begin
                irq_rise_en_i = N'($urandom);
                irq_fall_en_i = N'($urandom);
            end
            m = $urandom & $urandom & $urandom;
            io_pad_i  = io_pad_i ^ m[N-1:0];
            m = $urandom & $urandom & $urandom;
            irq_clr_i = m[N-1:0];
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
